uart_tx_buffered: RTL

- Serial UART transmitter, 8 data bits, LSB first, idle-high line; the transmit-side counterpart of the board's UART receive path.
- Accepts bytes from the CPU peripheral bus over a valid/ready handshake into a one-deep holding register, then serialises them on UART_TX.
- Holding register plus shifter allow back-to-back frames with zero idle gap.
- Sits in the pipeline FPGA top level beside the UART receiver and drives the board UART_TX pin.

---
 rtl/uart_tx_buffered.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_buffered.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_tx_buffered
//
// Serial UART transmitter. The frame has 8 data bits, sent LSB first, and the
// line idles high. Bytes arrive from the CPU peripheral bus over a valid/ready
// handshake and go into a one-deep holding register. A separate shifter drives
// the line, so the next byte can wait in the holding register while the
// current frame is still being sent. Frames can then run back to back with no
// idle gap between them.
//
// Parameters:
//   CLKS_PER_BIT : sysclk cycles per bit (minimum 4)
//   PARITY       : 0 = none, 1 = odd, 2 = even (parity bit follows D7)
//   STOP_BITS    : 1 or 2
//
// Ports:
//   sysclk   in   system clock, all logic on the rising edge
//   reset    in   synchronous active-low reset
//   tx_data  in   byte to send
//   tx_valid in   tx_data is valid
//   tx_ready out  holding register empty; a byte is accepted on
//                 tx_valid && tx_ready
//   tx_busy  out  a frame is on the line, or the holding register is full
//   UART_TX  out  serial line, driven straight from a flop
// -----------------------------------------------------------------------------
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       UART_TX
);

  localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      LAST_STOP = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [2:0]       bit_idx_q,   bit_idx_d;
  logic [7:0]       shift_q,     shift_d;
  logic             par_q,       par_d;
  logic             hold_full_q, hold_full_d;
  logic [7:0]       hold_data_q, hold_data_d;
  logic             tx_q,        tx_d;
  logic             tx_ready_q,  tx_ready_d;
  logic             tx_busy_q,   tx_busy_d;

  logic accept;
  logic load;
  logic baud_wrap;

  always_comb begin
    // NOTE: every variable gets a default first, so that no path through the
    // case statement leaves a value unassigned and infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    par_d       = par_q;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    load        = 1'b0;

    accept    = tx_valid && tx_ready_q;
    baud_wrap = (cnt_q == CNT_MAX);

    // The baud counter runs whenever a frame is active. Bits change only on
    // the wrap.
    if (state_q != S_IDLE) begin
      cnt_d = baud_wrap ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (hold_full_q) load = 1'b1;
      end
      S_START: begin
        if (baud_wrap) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (baud_wrap) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (baud_wrap) begin
          state_d   = S_STOP;
          bit_idx_d = '0;
        end
      end
      S_STOP: begin
        // bit_idx counts the stop bits here. On the last one, a waiting byte
        // starts at once, so no idle cycle appears between frames.
        if (baud_wrap) begin
          if (bit_idx_q == LAST_STOP) begin
            if (hold_full_q) load = 1'b1;
            else             state_d = S_IDLE;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      state_d     = S_START;
      cnt_d       = '0;
      bit_idx_d   = '0;
      shift_d     = hold_data_q;
      par_d       = (PARITY == 1) ? ~^hold_data_q : ^hold_data_q;
      hold_full_d = 1'b0;
    end

    // This comes after the load, so an accept in the same cycle as a load
    // leaves the register full with the new byte.
    if (accept) begin
      hold_full_d = 1'b1;
      hold_data_d = tx_data;
    end

    // The line level is decoded from the next state. That keeps UART_TX a
    // plain flop output, with no logic between the flop and the pin.
    case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase

    tx_ready_d = !hold_full_d;
    tx_busy_d  = (state_d != S_IDLE) || hold_full_d;
  end

  always_ff @(posedge sysclk) begin
    // NOTE: the datapath registers (shift, hold_data, parity) are reset along
    // with the control state. A reset mid-frame must throw the held byte away,
    // and this also keeps every flop free of X at start-up.
    if (!reset) begin
      // NOTE: sequential state is assigned non-blocking only. Every flop then
      // samples the values from before the edge, whatever the statement order.
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      tx_q        <= 1'b1;
      tx_ready_q  <= 1'b1;
      tx_busy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      tx_q        <= tx_d;
      tx_ready_q  <= tx_ready_d;
      tx_busy_q   <= tx_busy_d;
    end
  end

  assign UART_TX  = tx_q;
  assign tx_ready = tx_ready_q;
  assign tx_busy  = tx_busy_q;

endmodule
